// File: rtl/vscale_hasti_arbiter.sv
// N-port AHB-Lite (HASTI) arbiter: merges several upstream masters onto one
// downstream master port. Losing address phases are parked in a per-port
// holding register and reissued later; upstream sees only wait states.
// Optional feature: define HASTI_ARB_LOCK_EN to honour hmastlock sequences.
module vscale_hasti_arbiter #(
    parameter int unsigned N_PORTS  = 2,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [32*N_PORTS-1:0]  up_haddr,
    input  logic [N_PORTS-1:0]     up_hwrite,
    input  logic [3*N_PORTS-1:0]   up_hsize,
    input  logic [3*N_PORTS-1:0]   up_hburst,
    input  logic [N_PORTS-1:0]     up_hmastlock,
    input  logic [4*N_PORTS-1:0]   up_hprot,
    input  logic [2*N_PORTS-1:0]   up_htrans,
    input  logic [32*N_PORTS-1:0]  up_hwdata,
    output logic [31:0]            up_hrdata,
    output logic [N_PORTS-1:0]     up_hready,
    output logic [N_PORTS-1:0]     up_hresp,
    output logic [31:0]            haddr,
    output logic                   hwrite,
    output logic [2:0]             hsize,
    output logic [2:0]             hburst,
    output logic                   hmastlock,
    output logic [3:0]             hprot,
    output logic [1:0]             htrans,
    output logic [31:0]            hwdata,
    input  logic [31:0]            hrdata,
    input  logic                   hready,
    input  logic                   hresp
);

    localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    logic [31:0]        in_addr  [N_PORTS];
    logic [31:0]        in_wdata [N_PORTS];
    logic [2:0]         in_size  [N_PORTS];
    logic [3:0]         in_prot  [N_PORTS];

    logic [N_PORTS-1:0] held_valid;
    logic [31:0]        held_addr [N_PORTS];
    logic [2:0]         held_size [N_PORTS];
    logic [3:0]         held_prot [N_PORTS];
    logic [N_PORTS-1:0] held_write;
    logic [N_PORTS-1:0] held_lock;

    logic               dp_valid;
    logic [PW-1:0]      dp_owner;
    logic [PW-1:0]      last_grant;

    logic [N_PORTS-1:0] live;
    logic [N_PORTS-1:0] cand;
    logic               gnt_valid;
    logic [PW-1:0]      gnt_idx;
    logic [PW-1:0]      rr_idx;
    logic               sel_lock;

`ifdef HASTI_ARB_LOCK_EN
    logic               lock_active;
    logic [PW-1:0]      lock_owner;
`endif

    // Per-port slices of the flattened upstream buses; a live request is a
    // NONSEQ/SEQ seen while that port's HREADYOUT is high.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
        assign in_addr[gi]  = up_haddr[32*gi +: 32];
        assign in_wdata[gi] = up_hwdata[32*gi +: 32];
        assign in_size[gi]  = up_hsize[3*gi +: 3];
        assign in_prot[gi]  = up_hprot[4*gi +: 4];
        assign live[gi]     = up_htrans[2*gi+1] & up_hready[gi];
    end

    assign cand      = held_valid | live;
    assign up_hrdata = hrdata;
    assign hwdata    = dp_valid ? in_wdata[dp_owner] : 32'h0;

    // Upstream ready/response: data-phase owner follows the slave, a port
    // with a parked request stalls, everyone else is ready.
    always_comb begin
        up_hready = '1;
        up_hresp  = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (dp_valid && dp_owner == PW'(i)) begin
                up_hready[i] = hready;
                up_hresp[i]  = hresp;
            end else if (held_valid[i]) begin
                up_hready[i] = 1'b0;
            end
        end
    end

    // Arbitration: only on hready cycles and never while in reset.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        rr_idx    = '0;
        if (hready && hresetn) begin
            if (ARB_MODE == 0) begin
                for (int unsigned k = 1; k <= N_PORTS; k++) begin
                    rr_idx = PW'((32'(last_grant) + k) % N_PORTS);
                    if (!gnt_valid && cand[rr_idx]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = rr_idx;
                    end
                end
            end else begin
                for (int i = int'(N_PORTS) - 1; i >= 0; i--) begin
                    if (cand[i]) begin
                        gnt_valid = 1'b1;
                        gnt_idx   = PW'(i);
                    end
                end
            end
`ifdef HASTI_ARB_LOCK_EN
            if (lock_active) begin
                gnt_valid = cand[lock_owner];
                gnt_idx   = lock_owner;
            end
`endif
        end
    end

    // Downstream address phase from the parked or live request of the winner.
    always_comb begin
        haddr     = '0;
        hwrite    = 1'b0;
        hsize     = '0;
        hprot     = '0;
        htrans    = HTRANS_IDLE;
        hburst    = HBURST_SINGLE;
        hmastlock = 1'b0;
        sel_lock  = 1'b0;
        if (gnt_valid) begin
            htrans = HTRANS_NONSEQ;
            if (held_valid[gnt_idx]) begin
                haddr    = held_addr[gnt_idx];
                hwrite   = held_write[gnt_idx];
                hsize    = held_size[gnt_idx];
                hprot    = held_prot[gnt_idx];
                sel_lock = held_lock[gnt_idx];
            end else begin
                haddr    = in_addr[gnt_idx];
                hwrite   = up_hwrite[gnt_idx];
                hsize    = in_size[gnt_idx];
                hprot    = in_prot[gnt_idx];
                sel_lock = up_hmastlock[gnt_idx];
            end
`ifdef HASTI_ARB_LOCK_EN
            hmastlock = sel_lock;
`endif
        end
    end

    // Data-phase ownership and round-robin pointer advance on hready.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid   <= 1'b0;
            dp_owner   <= '0;
            last_grant <= PW'(N_PORTS - 1);
        end else if (hready) begin
            dp_valid <= gnt_valid;
            dp_owner <= gnt_idx;
            if (gnt_valid) begin
                last_grant <= gnt_idx;
            end
        end
    end

    // Holding registers: park a live request that lost, release on grant.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            held_valid <= '0;
            held_write <= '0;
            held_lock  <= '0;
            for (int i = 0; i < int'(N_PORTS); i++) begin
                held_addr[i] <= '0;
                held_size[i] <= '0;
                held_prot[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_PORTS); i++) begin
                if (gnt_valid && gnt_idx == PW'(i)) begin
                    held_valid[i] <= 1'b0;
                end else if (live[i]) begin
                    held_valid[i] <= 1'b1;
                    held_addr[i]  <= in_addr[i];
                    held_write[i] <= up_hwrite[i];
                    held_size[i]  <= in_size[i];
                    held_prot[i]  <= in_prot[i];
                    held_lock[i]  <= up_hmastlock[i];
                end
            end
        end
    end

`ifdef HASTI_ARB_LOCK_EN
    // Lock tracking: a locked grant pins the bus until the owner goes
    // unlocked or idle on a ready cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            lock_active <= 1'b0;
            lock_owner  <= '0;
        end else if (hready) begin
            if (lock_active) begin
                if (!gnt_valid || !sel_lock) begin
                    lock_active <= 1'b0;
                end
            end else if (gnt_valid && sel_lock) begin
                lock_active <= 1'b1;
                lock_owner  <= gnt_idx;
            end
        end
    end
`endif

    // Inputs the arbiter deliberately ignores (burst type, htrans[0]).
    logic unused_bits;
    assign unused_bits = ^{up_hburst, up_htrans, sel_lock, last_grant};

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: a 3-port round-robin instance and a 2-port
// fixed-priority instance share stimulus; a behavioural model predicts all
// outputs every cycle, plus hand-computed directed expectations.
module tb_vscale_hasti_arbiter;

`ifdef HASTI_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        hclk;
    logic        hresetn;
    logic [95:0] up_haddr;
    logic [2:0]  up_hwrite;
    logic [8:0]  up_hsize;
    logic [8:0]  up_hburst;
    logic [2:0]  up_hmastlock;
    logic [11:0] up_hprot;
    logic [5:0]  up_htrans;
    logic [95:0] up_hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    logic [31:0] up_hrdata, haddr, hwdata;
    logic [2:0]  up_hready, up_hresp, hsize, hburst;
    logic        hwrite, hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    logic [31:0] fp_up_hrdata, fp_haddr, fp_hwdata;
    logic [1:0]  fp_up_hready, fp_up_hresp;
    logic [2:0]  fp_hsize, fp_hburst;
    logic        fp_hwrite, fp_hmastlock;
    logic [3:0]  fp_hprot;
    logic [1:0]  fp_htrans;

    int n_checks = 0;
    int n_errors = 0;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    vscale_hasti_arbiter #(.N_PORTS(3), .ARB_MODE(0)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .up_haddr(up_haddr), .up_hwrite(up_hwrite), .up_hsize(up_hsize),
        .up_hburst(up_hburst), .up_hmastlock(up_hmastlock), .up_hprot(up_hprot),
        .up_htrans(up_htrans), .up_hwdata(up_hwdata),
        .up_hrdata(up_hrdata), .up_hready(up_hready), .up_hresp(up_hresp),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    vscale_hasti_arbiter #(.N_PORTS(2), .ARB_MODE(1)) dut_fp (
        .hclk(hclk), .hresetn(hresetn),
        .up_haddr(up_haddr[63:0]), .up_hwrite(up_hwrite[1:0]), .up_hsize(up_hsize[5:0]),
        .up_hburst(up_hburst[5:0]), .up_hmastlock(up_hmastlock[1:0]), .up_hprot(up_hprot[7:0]),
        .up_htrans(up_htrans[3:0]), .up_hwdata(up_hwdata[63:0]),
        .up_hrdata(fp_up_hrdata), .up_hready(fp_up_hready), .up_hresp(fp_up_hresp),
        .haddr(fp_haddr), .hwrite(fp_hwrite), .hsize(fp_hsize), .hburst(fp_hburst),
        .hmastlock(fp_hmastlock), .hprot(fp_hprot), .htrans(fp_htrans), .hwdata(fp_hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    // Model state, index 0 = round-robin/3 ports, 1 = fixed priority/2 ports.
    bit          s_hv [2][3], n_hv [2][3];
    logic [31:0] s_ha [2][3], n_ha [2][3];
    bit          s_hw [2][3], n_hw [2][3];
    logic [2:0]  s_hs [2][3], n_hs [2][3];
    logic [3:0]  s_hp [2][3], n_hp [2][3];
    bit          s_hl [2][3], n_hl [2][3];
    bit          s_dpv[2], n_dpv[2];
    int          s_dpo[2], n_dpo[2];
    int          s_last[2], n_last[2];
    bit          s_lka[2], n_lka[2];
    int          s_lko[2], n_lko[2];

    logic [1:0]  e_htrans[2];
    logic [31:0] e_haddr[2], e_hwdata[2];
    logic        e_hwrite[2], e_hmastlock[2];
    logic [2:0]  e_hsize[2], e_rdy[2], e_resp[2];
    logic [3:0]  e_hprot[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 3; i++) s_hv[m][i] = 1'b0;
            s_dpv[m]  = 1'b0;
            s_dpo[m]  = 0;
            s_last[m] = (m == 0) ? 2 : 1;
            s_lka[m]  = 1'b0;
            s_lko[m]  = 0;
        end
        n_hv = s_hv; n_dpv = s_dpv; n_dpo = s_dpo; n_last = s_last; n_lka = s_lka; n_lko = s_lko;
    endtask

    // Predict outputs of model m from current state and inputs, and its next state.
    task automatic eval(input int m);
        int n, g, best, d;
        bit glock, locked;
        bit live[3];
        bit cand[3];
        n = (m == 0) ? 3 : 2;
        g = -1; best = n; glock = 1'b0; locked = 1'b0;
        e_rdy[m] = '0; e_resp[m] = '0;
        for (int i = 0; i < 3; i++) begin live[i] = 1'b0; cand[i] = 1'b0; end
        for (int i = 0; i < n; i++) begin
            if (s_dpv[m] && s_dpo[m] == i) begin
                e_rdy[m][i]  = hready;
                e_resp[m][i] = hresp;
            end else begin
                e_rdy[m][i] = !s_hv[m][i];
            end
            live[i] = up_htrans[2*i+1] && e_rdy[m][i];
            cand[i] = s_hv[m][i] || live[i];
        end
        if (hresetn && hready) begin
            if (LOCK_EN && s_lka[m]) begin
                locked = 1'b1;
                if (cand[s_lko[m]]) g = s_lko[m];
            end
            if (!locked && m == 1) begin
                for (int i = 0; i < n; i++) if (g < 0 && cand[i]) g = i;
            end else if (!locked) begin
                // distance from the port after the last winner, wrapping around
                for (int i = 0; i < n; i++) begin
                    if (cand[i]) begin
                        d = (i - s_last[m] - 1 + 2 * n) % n;
                        if (d < best) begin best = d; g = i; end
                    end
                end
            end
        end
        e_htrans[m] = 2'b00; e_haddr[m] = '0; e_hwrite[m] = 1'b0;
        e_hsize[m] = '0; e_hprot[m] = '0; e_hmastlock[m] = 1'b0;
        if (g >= 0) begin
            e_htrans[m] = 2'b10;
            if (s_hv[m][g]) begin
                e_haddr[m] = s_ha[m][g]; e_hwrite[m] = s_hw[m][g];
                e_hsize[m] = s_hs[m][g]; e_hprot[m] = s_hp[m][g]; glock = s_hl[m][g];
            end else begin
                e_haddr[m] = up_haddr[32*g +: 32]; e_hwrite[m] = up_hwrite[g];
                e_hsize[m] = up_hsize[3*g +: 3]; e_hprot[m] = up_hprot[4*g +: 4];
                glock = up_hmastlock[g];
            end
            e_hmastlock[m] = LOCK_EN && glock;
        end
        e_hwdata[m] = s_dpv[m] ? up_hwdata[32*s_dpo[m] +: 32] : 32'h0;

        for (int i = 0; i < 3; i++) begin
            n_hv[m][i] = s_hv[m][i]; n_ha[m][i] = s_ha[m][i]; n_hw[m][i] = s_hw[m][i];
            n_hs[m][i] = s_hs[m][i]; n_hp[m][i] = s_hp[m][i]; n_hl[m][i] = s_hl[m][i];
        end
        n_dpv[m] = s_dpv[m]; n_dpo[m] = s_dpo[m]; n_last[m] = s_last[m];
        n_lka[m] = s_lka[m]; n_lko[m] = s_lko[m];
        if (hready && hresetn) begin
            n_dpv[m] = (g >= 0);
            if (g >= 0) begin n_dpo[m] = g; n_last[m] = g; end
            if (LOCK_EN) begin
                if (s_lka[m]) begin
                    if (g < 0 || !glock) n_lka[m] = 1'b0;
                end else if (g >= 0 && glock) begin
                    n_lka[m] = 1'b1; n_lko[m] = g;
                end
            end
        end
        for (int i = 0; i < n; i++) begin
            if (i == g) n_hv[m][i] = 1'b0;
            else if (live[i] && hresetn) begin
                n_hv[m][i] = 1'b1; n_ha[m][i] = up_haddr[32*i +: 32];
                n_hw[m][i] = up_hwrite[i]; n_hs[m][i] = up_hsize[3*i +: 3];
                n_hp[m][i] = up_hprot[4*i +: 4]; n_hl[m][i] = up_hmastlock[i];
            end
        end
    endtask

    // Sample at the falling edge and compare both instances against the model.
    task automatic settle();
        @(negedge hclk);
        eval(0);
        eval(1);
        chk("rr htrans", 32'(htrans), 32'(e_htrans[0]));
        chk("rr haddr", haddr, e_haddr[0]);
        chk("rr hwrite", 32'(hwrite), 32'(e_hwrite[0]));
        chk("rr hsize", 32'(hsize), 32'(e_hsize[0]));
        chk("rr hprot", 32'(hprot), 32'(e_hprot[0]));
        chk("rr hburst", 32'(hburst), 32'h0);
        chk("rr hmastlock", 32'(hmastlock), 32'(e_hmastlock[0]));
        chk("rr hwdata", hwdata, e_hwdata[0]);
        chk("rr up_hready", 32'(up_hready), 32'(e_rdy[0]));
        chk("rr up_hresp", 32'(up_hresp), 32'(e_resp[0]));
        chk("rr up_hrdata", up_hrdata, hrdata);
        chk("fp htrans", 32'(fp_htrans), 32'(e_htrans[1]));
        chk("fp haddr", fp_haddr, e_haddr[1]);
        chk("fp hwrite", 32'(fp_hwrite), 32'(e_hwrite[1]));
        chk("fp hsize", 32'(fp_hsize), 32'(e_hsize[1]));
        chk("fp hprot", 32'(fp_hprot), 32'(e_hprot[1]));
        chk("fp hmastlock", 32'(fp_hmastlock), 32'(e_hmastlock[1]));
        chk("fp hwdata", fp_hwdata, e_hwdata[1]);
        chk("fp up_hready", 32'(fp_up_hready), 32'(e_rdy[1]));
        chk("fp up_hresp", 32'(fp_up_hresp), 32'(e_resp[1]));
    endtask

    // Rising edge: model takes its predicted next state (or resets), then inputs may change.
    task automatic advance();
        @(posedge hclk);
        if (!hresetn) reset_model();
        else begin
            s_hv = n_hv; s_ha = n_ha; s_hw = n_hw; s_hs = n_hs; s_hp = n_hp; s_hl = n_hl;
            s_dpv = n_dpv; s_dpo = n_dpo; s_last = n_last; s_lka = n_lka; s_lko = n_lko;
        end
        #1;
    endtask

    task automatic set_port(input int p, input logic [1:0] tr, input logic [31:0] a,
                            input logic wr, input logic lk);
        up_htrans[2*p +: 2]  = tr;
        up_haddr[32*p +: 32] = a;
        up_hwrite[p]         = wr;
        up_hmastlock[p]      = lk;
        up_hsize[3*p +: 3]   = 3'd2;
        up_hprot[4*p +: 4]   = 4'h3;
        up_hburst[3*p +: 3]  = 3'd1;
    endtask

    task automatic idle_all();
        for (int p = 0; p < 3; p++) set_port(p, 2'b00, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        hresetn = 1'b0; hready = 1'b1; hresp = 1'b0; hrdata = '0; up_hwdata = '0;
        idle_all();
        reset_model();

        // reset values
        settle();
        chk("reset htrans", 32'(htrans), 32'h0);
        chk("reset up_hready", 32'(up_hready), 32'h7);
        chk("reset up_hresp", 32'(up_hresp), 32'h0);
        chk("reset haddr", haddr, 32'h0);
        chk("reset fp up_hready", 32'(fp_up_hready), 32'h3);
        advance();
        hresetn = 1'b1;

        // collision straight after reset: port 0 first, port 1 parked one cycle
        set_port(0, 2'b10, 32'h200, 1'b0, 1'b0);
        set_port(1, 2'b10, 32'h300, 1'b1, 1'b0);
        settle();
        chk("coll first haddr", haddr, 32'h200);
        chk("coll first htrans", 32'(htrans), 32'h2);
        chk("coll fp first haddr", fp_haddr, 32'h200);
        advance();
        set_port(0, 2'b00, 32'h0, 1'b0, 1'b0);
        settle();
        chk("coll held rdy", 32'(up_hready), 32'h5);
        chk("coll second haddr", haddr, 32'h300);
        chk("coll second hwrite", 32'(hwrite), 32'h1);
        advance();
        set_port(1, 2'b00, 32'h0, 1'b0, 1'b0);
        up_hwdata[63:32] = 32'hD00DF00D;
        settle();
        chk("coll wdata", hwdata, 32'hD00DF00D);
        chk("coll rdy back", 32'(up_hready), 32'h7);
        advance();

        // single uncontended read
        set_port(0, 2'b10, 32'h100, 1'b0, 1'b0);
        settle();
        chk("single haddr", haddr, 32'h100);
        chk("single htrans", 32'(htrans), 32'h2);
        advance();
        set_port(0, 2'b00, 32'h0, 1'b0, 1'b0);
        hrdata = 32'hCAFE0100;
        settle();
        chk("single hrdata", up_hrdata, 32'hCAFE0100);
        chk("single rdy", 32'(up_hready), 32'h7);
        advance();

        // three downstream wait states while port 1 requests
        set_port(1, 2'b10, 32'h400, 1'b0, 1'b0);
        hready = 1'b0;
        settle();
        chk("wait c0 htrans", 32'(htrans), 32'h0);
        advance();
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("wait htrans", 32'(htrans), 32'h0);
            chk("wait held rdy", 32'(up_hready), 32'h5);
            advance();
        end
        hready = 1'b1;
        settle();
        chk("wait issue haddr", haddr, 32'h400);
        chk("wait issue htrans", 32'(htrans), 32'h2);
        advance();
        set_port(1, 2'b00, 32'h0, 1'b0, 1'b0);
        settle();
        advance();

        // two-cycle ERROR on port 1's write
        set_port(1, 2'b10, 32'h500, 1'b1, 1'b0);
        settle();
        chk("err issue haddr", haddr, 32'h500);
        advance();
        set_port(1, 2'b00, 32'h0, 1'b0, 1'b0);
        hready = 1'b0; hresp = 1'b1;
        settle();
        chk("err c1 resp", 32'(up_hresp), 32'h2);
        chk("err c1 rdy", 32'(up_hready), 32'h5);
        advance();
        hready = 1'b1;
        settle();
        chk("err c2 resp", 32'(up_hresp), 32'h2);
        chk("err c2 rdy", 32'(up_hready), 32'h7);
        advance();
        hresp = 1'b0;

        // reset asserted mid-transfer
        set_port(0, 2'b10, 32'h600, 1'b1, 1'b0);
        settle();
        chk("mid issue haddr", haddr, 32'h600);
        advance();
        set_port(0, 2'b00, 32'h0, 1'b0, 1'b0);
        set_port(1, 2'b10, 32'h610, 1'b0, 1'b0);
        up_hwdata[31:0] = 32'hAAAA5555;
        hready = 1'b0;
        settle();
        chk("mid wdata", hwdata, 32'hAAAA5555);
        hresetn = 1'b0;
        #1;
        reset_model();
        chk("mid rst htrans", 32'(htrans), 32'h0);
        chk("mid rst haddr", haddr, 32'h0);
        chk("mid rst hwdata", hwdata, 32'h0);
        chk("mid rst up_hready", 32'(up_hready), 32'h7);
        chk("mid rst up_hresp", 32'(up_hresp), 32'h0);
        chk("mid rst fp up_hready", 32'(fp_up_hready), 32'h3);
        advance();
        hresetn = 1'b1;
        hready = 1'b1;
        idle_all();

        // fairness: both ports request continuously
        set_port(0, 2'b10, 32'hA000, 1'b0, 1'b0);
        set_port(1, 2'b10, 32'hB000, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("fair rr haddr", haddr, (k % 2 == 0) ? 32'hA000 : 32'hB000);
            chk("fair fp haddr", fp_haddr, 32'hA000);
            advance();
        end
        idle_all();
        settle();
        advance();

`ifdef HASTI_ARB_LOCK_EN
        // port 1 holds a locked sequence of three transfers while port 0 waits
        set_port(1, 2'b10, 32'h700, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("lock haddr", haddr, 32'h700);
            chk("lock hmastlock", 32'(hmastlock), 32'h1);
            advance();
            set_port(0, 2'b10, 32'h800, 1'b0, 1'b0);
        end
        set_port(1, 2'b00, 32'h0, 1'b0, 1'b0);
        settle();
        chk("lock release idle", 32'(htrans), 32'h0);
        advance();
        set_port(0, 2'b00, 32'h0, 1'b0, 1'b0);
        settle();
        chk("lock after haddr", haddr, 32'h800);
        advance();
        idle_all();
        settle();
        advance();
`endif

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 1) == 0) begin
                    up_htrans[2*p +: 2]  = 2'($urandom_range(0, 3));
                    up_haddr[32*p +: 32] = $urandom;
                    up_hwrite[p]         = 1'($urandom_range(0, 1));
                    up_hsize[3*p +: 3]   = 3'($urandom_range(0, 2));
                    up_hprot[4*p +: 4]   = 4'($urandom_range(0, 15));
                    up_hburst[3*p +: 3]  = 3'($urandom_range(0, 7));
                    up_hmastlock[p]      = ($urandom_range(0, 3) == 0);
                end
                up_hwdata[32*p +: 32] = $urandom;
            end
            hready = ($urandom_range(0, 3) != 0);
            hresp  = ($urandom_range(0, 7) == 0);
            hrdata = $urandom;
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vscale_hasti_arbiter.md
# vscale_hasti_arbiter

N-port AHB-Lite (HASTI) arbiter merging several upstream masters, e.g. a core's imem and dmem bridges, onto one downstream AHB-Lite master port, so a single-ported memory or bus can serve the whole core. It sits between the bridges and the system bus. It accepts address phases from every port, holds any that lose arbitration, and reissues them in round-robin or fixed-priority order. Upstream masters see these losses only as data-phase wait states.

## Interface
Parameters:
- N_PORTS, 2, number of upstream ports (1..8)
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with port 0 highest

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  reset; asynchronous, active-low
- up_haddr  in  32*N_PORTS  per-port address, port i at bits [32i+31:32i]
- up_hwrite  in  N_PORTS  per-port write
- up_hsize  in  3*N_PORTS  per-port size
- up_hburst  in  3*N_PORTS  per-port burst (ignored)
- up_hmastlock  in  N_PORTS  per-port lock
- up_hprot  in  4*N_PORTS  per-port protection
- up_htrans  in  2*N_PORTS  per-port transfer type
- up_hwdata  in  32*N_PORTS  per-port write data
- up_hrdata  out  32  read data, broadcast to all ports
- up_hready  out  N_PORTS  per-port HREADYOUT
- up_hresp  out  N_PORTS  per-port response
- haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata  out  32/1/3/3/1/4/2/32  downstream master signals
- hrdata  in  32  downstream read data
- hready  in  1  downstream ready
- hresp  in  1  downstream response

## Operation
- A port has a live request when up_htrans[i][1] = 1 and up_hready[i] = 1 in the same cycle.
- Held request:
  - Each port has one holding register: valid, addr, write, size, prot, lock.
  - A live request that is not granted this cycle is captured into it.
  - A port with a held request has up_hready = 0, so at most one request per port is held.
- Candidates: held[i] | live[i]. Held and live are mutually exclusive per port.
- Grant:
  - Granting happens only when hready = 1.
  - ARB_MODE 0: the first candidate searching upward (modulo N_PORTS) from last_grant+1. last_grant resets to N_PORTS-1, so port 0 wins first.
  - ARB_MODE 1: the lowest-index candidate wins.
- Issue:
  - The granted request drives the downstream signals: htrans = NONSEQ, hburst = SINGLE, and the held or live haddr/hwrite/hsize/hprot.
  - With no grant, or with hready = 0, htrans = IDLE and the other address signals are don't-care (driven 0).
  - Held[g] clears on grant.
- Data phase:
  - On hready = 1: dp_valid <= grant, dp_owner <= g.
  - hwdata = up_hwdata[dp_owner].
- Upstream ready and response for port i:
  - If dp_valid and dp_owner == i: up_hready = hready and up_hresp = hresp.
  - Else if held[i]: up_hready = 0 and up_hresp = 0.
  - Else: up_hready = 1 and up_hresp = 0.
- Downstream two-cycle ERROR responses pass through to the owner unchanged.
- SEQ/BUSY: SEQ is issued as NONSEQ. BUSY is treated as IDLE.

## Timing
- Reset values:
  - All held = 0, dp_valid = 0, last_grant = N_PORTS-1.
  - htrans = IDLE, hmastlock = 0, and the other downstream outputs are 0.
  - up_hready = all 1s, up_hresp = 0.
- Uncontended live request with hready = 1: issued downstream in the same cycle, zero added latency.
- Losing or stalled request: issued at the earliest later cycle with hready = 1 in which it wins. The owning port sees one up_hready-low cycle per cycle of delay.
- Simultaneous events:
  - Owner completing its data phase and presenting a new address in the same cycle is a normal pipelined transfer.
  - If that new address loses, it is held, and the port's next cycle shows up_hready = 0.
- Reset mid-transfer: all state clears asynchronously and held requests are discarded.

## Configuration
- HASTI_ARB_LOCK_EN defined:
  - A port granted with lock = 1 keeps the grant against all others while it presents locked requests.
  - Arbitration resumes after the first granted cycle in which that port presents lock = 0 or IDLE.
  - hmastlock is driven from the granted request.
- HASTI_ARB_LOCK_EN undefined: up_hmastlock is ignored and hmastlock = 0.

## Test plan
- Single port: port 0 reads 0x100 with hready held 1 -> NONSEQ at 0x100 in the same cycle, hrdata returned next cycle, up_hready[0] never low.
- Collision: ports 0 and 1 both issue NONSEQ in the same cycle, ARB_MODE 0, after reset -> port 0 issued first, port 1 held, up_hready[1] = 0 for one cycle, port 1 issued the next cycle.
- Fairness: ports 0 and 1 request continuously for 8 transfers, ARB_MODE 0 -> grants alternate 0,1,0,1. With ARB_MODE 1 -> port 0 gets all of them.
- Wait states: downstream holds hready = 0 for 3 cycles while port 1 requests -> htrans = IDLE during the waits, port 1 held, then issued on the first hready = 1.
- Error: downstream ERROR (hresp = 1 for 2 cycles) on port 1's write -> up_hresp[1] mirrors it, up_hresp[0] = 0. Also, asserting hresetn low mid-transfer -> all outputs return to their reset values immediately.
- HASTI_ARB_LOCK_EN: port 1 issues 3 locked transfers while port 0 requests -> port 0 waits until port 1's lock drops.
